z80_int_ctrl: RTL and testbench

- Maskable interrupt controller for the Z80 board CPLD. Drives the CPU INT line, which is currently tied inactive.
- Collects four sources: the 16550 UART interrupt, an internal periodic timer, and two external pins. Supplies the Z80 IM2 vector during the interrupt-acknowledge cycle.
- Sits beside the memory mapper and system register on the same I/O decode. The top level merges its split data bus onto D.

---
 rtl/z80_int_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: maskable interrupt controller for the Z80 board CPLD.
// Collects UART (level), periodic timer and two external edge sources, drives
// the active-low INT line and supplies the IM2 vector during the acknowledge cycle.
// Ports:
//   CLK_24MHz, RES         clock, async active-low reset
//   A_L, D_IN              CPU address [7:0] and write data (sampled unsynchronized)
//   D_OUT, D_OE            read data / vector and its bus-drive enable (combinational)
//   IORQ, M1, RD, WR       Z80 strobes, active-low
//   U_INT, EXT_INT[1:0]    interrupt sources
//   INT                    Z80 INT, active-low, registered
module z80_int_ctrl #(
  parameter int unsigned TIMER_DIV = 480000,
  parameter logic [7:0]  PORT_MASK = 8'h21,
  parameter logic [7:0]  PORT_PEND = 8'h22,
  parameter logic [7:0]  PORT_VEC  = 8'h23,
  parameter logic [7:0]  PORT_CTRL = 8'h24
) (
  input  logic       CLK_24MHz,
  input  logic       RES,
  input  logic [7:0] A_L,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic       IORQ,
  input  logic       M1,
  input  logic       RD,
  input  logic       WR,
  input  logic       U_INT,
  input  logic [1:0] EXT_INT,
  output logic       INT
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned SRC_N = 4;

  typedef enum logic {S_IDLE, S_ACK} ack_state_t;

  // strobe order in the synchronizer vectors: {IORQ, M1, RD, WR}
  logic [3:0]       strb_s1, strb_s2;
  logic             u_s1, u_s2;
  logic [1:0]       ext_s1, ext_s2, ext_s3;
  logic             iorq_s, m1_s, rd_s, wr_s;

  logic [7:0]       mask_q;
  logic [3:0]       vec_q;
  logic [1:0]       ctrl_q;
  logic [2:0]       pend_q;       // pending[3:1]; pending[0] is the live UART level
  logic [CNT_W-1:0] cnt_q;
  logic             wr_act_q;
  logic [2:0]       hp_idx_q;
  logic             int_n_q;
  ack_state_t       state_q, state_d;

  logic             wr_act, wr_stb;
  logic             wr_mask, wr_pend, wr_vec, wr_ctrl;
  logic             cnt_end, tmr_wrap;
  logic [1:0]       ext_rise;
  logic [SRC_N-1:0] pending, active;
  logic [2:0]       hp_idx_d;
  logic [2:0]       ack_clr, w1c_clr, pend_set;

  // Two-flop synchronizers; the extra external stage feeds edge detection.
  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      strb_s1 <= 4'hF;
      strb_s2 <= 4'hF;
      u_s1    <= 1'b0;
      u_s2    <= 1'b0;
      ext_s1  <= 2'b00;
      ext_s2  <= 2'b00;
      ext_s3  <= 2'b00;
    end else begin
      strb_s1 <= {IORQ, M1, RD, WR};
      strb_s2 <= strb_s1;
      u_s1    <= U_INT;
      u_s2    <= u_s1;
      ext_s1  <= EXT_INT;
      ext_s2  <= ext_s1;
      ext_s3  <= ext_s2;
    end
  end

  assign {iorq_s, m1_s, rd_s, wr_s} = strb_s2;

  // One write per I/O cycle; RD and WR both low is malformed and ignored.
  assign wr_act  = ~iorq_s & ~wr_s & rd_s;
  assign wr_stb  = wr_act & ~wr_act_q;
  assign wr_mask = wr_stb && (A_L == PORT_MASK);
  assign wr_pend = wr_stb && (A_L == PORT_PEND);
  assign wr_vec  = wr_stb && (A_L == PORT_VEC);
  assign wr_ctrl = wr_stb && (A_L == PORT_CTRL);

  // A wrap coinciding with the timer being switched off is dropped.
  assign cnt_end  = (cnt_q == CNT_W'(TIMER_DIV - 1));
  assign tmr_wrap = ctrl_q[1] & cnt_end & ~(wr_ctrl & ~D_IN[1]);
  assign ext_rise = ext_s2 & ~ext_s3;

  assign pending = {pend_q, u_s2};
  assign active  = pending & mask_q[3:0];

  // Lowest-numbered active source wins; 4 marks a spurious acknowledge.
  always_comb begin
    hp_idx_d = 3'd4;
    if      (active[0]) hp_idx_d = 3'd0;
    else if (active[1]) hp_idx_d = 3'd1;
    else if (active[2]) hp_idx_d = 3'd2;
    else if (active[3]) hp_idx_d = 3'd3;
  end

  // Ack FSM next state and the pending clear on the way out of ACK.
  always_comb begin
    state_d = state_q;
    ack_clr = 3'b000;
    case (state_q)
      S_IDLE: if (!m1_s && !iorq_s) state_d = S_ACK;
      S_ACK: begin
        if (m1_s || iorq_s) begin
          state_d = S_IDLE;
          case (hp_idx_q)
            3'd1:    ack_clr = 3'b001;
            3'd2:    ack_clr = 3'b010;
            3'd3:    ack_clr = 3'b100;
            default: ack_clr = 3'b000;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w1c_clr  = wr_pend ? D_IN[3:1] : 3'b000;
  assign pend_set = {ext_rise, tmr_wrap};

  // Registers, timer, pending latch (set beats clear), priority and INT.
  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      state_q  <= S_IDLE;
      mask_q   <= 8'h00;
      vec_q    <= 4'h0;
      ctrl_q   <= 2'b00;
      pend_q   <= 3'b000;
      cnt_q    <= '0;
      wr_act_q <= 1'b0;
      hp_idx_q <= 3'd4;
      int_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_act_q <= wr_act;
      if (wr_mask) mask_q <= D_IN;
      if (wr_vec)  vec_q  <= D_IN[7:4];
      if (wr_ctrl) ctrl_q <= D_IN[1:0];
      if (!ctrl_q[1] || cnt_end) cnt_q <= '0;
      else                       cnt_q <= cnt_q + CNT_W'(1);
      pend_q   <= (pend_q & ~(w1c_clr | ack_clr)) | pend_set;
      if (m1_s) hp_idx_q <= hp_idx_d;
      int_n_q  <= ~(ctrl_q[0] & |active);
    end
  end

  assign INT = int_n_q;

  // Bus drive from the raw strobes so it follows the CPU without sync delay.
  always_comb begin
    D_OE  = 1'b0;
    D_OUT = 8'h00;
    if (RES) begin
      if (!M1 && !IORQ) begin
        D_OE  = 1'b1;
        D_OUT = {vec_q, hp_idx_q, 1'b0};
      end else if (!IORQ && !RD) begin
        case (A_L)
          PORT_MASK: begin D_OE = 1'b1; D_OUT = mask_q;              end
          PORT_PEND: begin D_OE = 1'b1; D_OUT = {4'b0000, pending};  end
          PORT_VEC:  begin D_OE = 1'b1; D_OUT = {vec_q, 4'b0000};    end
          PORT_CTRL: begin D_OE = 1'b1; D_OUT = {6'b000000, ctrl_q}; end
          default:   begin D_OE = 1'b0; D_OUT = 8'h00;               end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Bench for z80_int_ctrl with a short timer period; expected bytes are queued
// when a transaction starts and popped when the DUT presents its data.
module tb_z80_int_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [7:0] a_l = 8'hFF;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic       iorq = 1'b1, m1 = 1'b1, rd = 1'b1, wr = 1'b1;
  logic       u_int = 1'b0;
  logic [1:0] ext_int = 2'b00;
  logic       int_n;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];

  z80_int_ctrl #(.TIMER_DIV(10)) dut (
    .CLK_24MHz(clk), .RES(res), .A_L(a_l), .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe),
    .IORQ(iorq), .M1(m1), .RD(rd), .WR(wr), .U_INT(u_int), .EXT_INT(ext_int), .INT(int_n)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    a_l = a; d_in = d; iorq = 1'b0; wr = 1'b0;
    repeat (4) @(negedge clk);
    iorq = 1'b1; wr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    a_l = a; iorq = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    d = d_out; oe = d_oe;
    iorq = 1'b1; rd = 1'b1;
    @(negedge clk);
  endtask

  task automatic int_ack(output logic [7:0] v, output logic oe);
    a_l = 8'hFF; m1 = 1'b0;
    repeat (2) @(negedge clk);
    iorq = 1'b0;
    repeat (2) @(negedge clk);
    v = d_out; oe = d_oe;
    m1 = 1'b1; iorq = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ext(input logic [1:0] v);
    ext_int = v;
    repeat (3) @(negedge clk);
    ext_int = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_int_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int_n === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d, e;
    logic oe;
    logic [7:0] ports[4];
    ports = '{8'h21, 8'h22, 8'h23, 8'h24};
    repeat (3) @(negedge clk);
    n_vec++;
    if (d_oe !== 1'b0 || int_n !== 1'b1) begin
      n_err++; $display("FAIL reset_pins: D_OE=%b INT=%b, want 0/1", d_oe, int_n);
    end
    res = 1'b1;
    repeat (3) @(negedge clk);
    foreach (ports[i]) begin
      exp_q.push_back(8'h00);
      io_read(ports[i], d, oe);
      e = exp_q.pop_front();
      n_vec++;
      if (d !== e || oe !== 1'b1) begin
        n_err++; $display("FAIL reset_read_%h: got %h oe=%b, want %h oe=1", ports[i], d, oe, e);
      end
    end
    n_vec++;
    if (d_oe !== 1'b0 || int_n !== 1'b1) begin
      n_err++; $display("FAIL reset_idle: D_OE=%b INT=%b, want 0/1", d_oe, int_n);
    end
  endtask

  task automatic test_uart;
    logic [7:0] d, e;
    logic oe;
    io_write(8'h24, 8'h01);
    io_write(8'h21, 8'h01);
    io_write(8'h23, 8'hA0);
    u_int = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (int_n !== 1'b0) begin n_err++; $display("FAIL uart_int: INT=%b, want 0", int_n); end
    exp_q.push_back(8'hA0);
    int_ack(d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || oe !== 1'b1) begin
      n_err++; $display("FAIL uart_vec: got %h oe=%b, want %h oe=1", d, oe, e);
    end
    u_int = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (int_n !== 1'b1) begin n_err++; $display("FAIL uart_drop: INT=%b, want 1", int_n); end
    exp_q.push_back(8'h00);
    io_read(8'h22, d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e) begin n_err++; $display("FAIL uart_pend: got %h, want %h", d, e); end
  endtask

  task automatic test_timer;
    logic [7:0] d, e;
    logic oe;
    bit ok;
    int t1, t2;
    io_write(8'h21, 8'h02);
    io_write(8'h24, 8'h03);
    wait_int_low(40, ok);
    t1 = cyc;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL timer_first: INT=%b after 40 clocks, want 0", int_n); end
    io_write(8'h22, 8'h02);
    n_vec++;
    if (int_n !== 1'b1) begin n_err++; $display("FAIL timer_w1c: INT=%b, want 1", int_n); end
    wait_int_low(20, ok);
    t2 = cyc;
    n_vec++;
    if (!ok || (t2 - t1) != 10) begin
      n_err++; $display("FAIL timer_period: ok=%b period=%0d, want 10", ok, t2 - t1);
    end
    // Tick landed on edge t2-1; time the ack end onto the next tick at t2+9.
    a_l = 8'hFF; m1 = 1'b0;
    @(negedge clk);
    iorq = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'hA2);
    d = d_out;
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || d_oe !== 1'b1) begin
      n_err++; $display("FAIL timer_vec: got %h oe=%b, want %h oe=1", d, d_oe, e);
    end
    while (cyc < t2 + 6) @(negedge clk);
    m1 = 1'b1; iorq = 1'b1;
    while (cyc < t2 + 10) @(negedge clk);
    n_vec++;
    if (int_n !== 1'b0) begin n_err++; $display("FAIL timer_collide: INT=%b, want 0", int_n); end
    io_write(8'h24, 8'h01);
    exp_q.push_back(8'hA2);
    int_ack(d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e) begin n_err++; $display("FAIL timer_vec2: got %h, want %h", d, e); end
    exp_q.push_back(8'h00);
    io_read(8'h22, d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || int_n !== 1'b1) begin
      n_err++; $display("FAIL timer_cleared: pend=%h INT=%b, want %h INT=1", d, int_n, e);
    end
  endtask

  task automatic test_priority;
    logic [7:0] d, e;
    logic oe;
    logic [7:0] want[2];
    want = '{8'hA4, 8'hA6};
    io_write(8'h21, 8'h0C);
    pulse_ext(2'b11);
    n_vec++;
    if (int_n !== 1'b0) begin n_err++; $display("FAIL prio_int: INT=%b, want 0", int_n); end
    foreach (want[i]) begin
      exp_q.push_back(want[i]);
      int_ack(d, oe);
      e = exp_q.pop_front();
      n_vec++;
      if (d !== e) begin n_err++; $display("FAIL prio_ack%0d: got %h, want %h", i, d, e); end
    end
    // Higher-priority edge arrives after M1 has frozen the index.
    pulse_ext(2'b10);
    exp_q.push_back(8'hA6);
    a_l = 8'hFF; m1 = 1'b0;
    repeat (3) @(negedge clk);
    ext_int = 2'b01; iorq = 1'b0;
    repeat (5) @(negedge clk);
    d = d_out;
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e) begin n_err++; $display("FAIL freeze_vec: got %h, want %h", d, e); end
    m1 = 1'b1; iorq = 1'b1; ext_int = 2'b00;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h04);
    io_read(8'h22, d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e) begin n_err++; $display("FAIL freeze_pend: got %h, want %h", d, e); end
    io_write(8'h22, 8'h04);
  endtask

  task automatic test_w1c_mask;
    logic [7:0] d, e;
    logic oe;
    io_write(8'h21, 8'h00);
    pulse_ext(2'b01);
    n_vec++;
    if (int_n !== 1'b1) begin n_err++; $display("FAIL masked_int: INT=%b, want 1", int_n); end
    exp_q.push_back(8'h04);
    io_read(8'h22, d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e) begin n_err++; $display("FAIL masked_pend: got %h, want %h", d, e); end
    io_write(8'h21, 8'h04);
    n_vec++;
    if (int_n !== 1'b0) begin n_err++; $display("FAIL unmask_int: INT=%b, want 0", int_n); end
    io_write(8'h22, 8'h04);
    n_vec++;
    if (int_n !== 1'b1) begin n_err++; $display("FAIL w1c_int: INT=%b, want 1", int_n); end
    pulse_ext(2'b01);
    // Edge and W1C travel equal synchronizer depth, so they meet on one clock.
    a_l = 8'h22; d_in = 8'h04; iorq = 1'b0; wr = 1'b0; ext_int = 2'b01;
    repeat (4) @(negedge clk);
    iorq = 1'b1; wr = 1'b1; ext_int = 2'b00;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h04);
    io_read(8'h22, d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || int_n !== 1'b0) begin
      n_err++; $display("FAIL w1c_collide: pend=%h INT=%b, want %h INT=0", d, int_n, e);
    end
    io_write(8'h22, 8'h0E);
  endtask

  task automatic test_spurious_reset;
    logic [7:0] d, e;
    logic oe;
    logic [7:0] ports[4];
    ports = '{8'h21, 8'h22, 8'h23, 8'h24};
    exp_q.push_back(8'hA8);
    int_ack(d, oe);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || oe !== 1'b1) begin
      n_err++; $display("FAIL spurious_vec: got %h oe=%b, want %h oe=1", d, oe, e);
    end
    a_l = 8'hFF; m1 = 1'b0;
    repeat (2) @(negedge clk);
    iorq = 1'b0;
    repeat (2) @(negedge clk);
    #2 res = 1'b0;
    #1;
    n_vec++;
    if (d_oe !== 1'b0 || int_n !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ack: D_OE=%b INT=%b, want 0/1", d_oe, int_n);
    end
    m1 = 1'b1; iorq = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b1;
    repeat (3) @(negedge clk);
    foreach (ports[i]) begin
      exp_q.push_back(8'h00);
      io_read(ports[i], d, oe);
      e = exp_q.pop_front();
      n_vec++;
      if (d !== e) begin n_err++; $display("FAIL post_reset_%h: got %h, want %h", ports[i], d, e); end
    end
  endtask

  initial begin
    test_reset;
    test_uart;
    test_timer;
    test_priority;
    test_w1c_mask;
    test_spurious_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
